// File: rtl/tc_pl_cap_acptx_sched_if.sv
// rtl/tc_pl_cap_acptx_sched_if.sv - scheduler to ACP TX capture engine control interface
interface tc_pl_cap_acptx_sched_if #(
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] eng_sel;
    logic             eng_tacp_en;
    logic [31:0]      eng_cap_addr;
    logic             eng_tacp_cmpt;
    logic             eng_burst_done;

    modport master (
        output eng_sel,
        output eng_tacp_en,
        output eng_cap_addr,
        input  eng_tacp_cmpt,
        input  eng_burst_done
    );

    modport slave (
        input  eng_sel,
        input  eng_tacp_en,
        input  eng_cap_addr,
        output eng_tacp_cmpt,
        output eng_burst_done
    );
endinterface

// File: rtl/tc_pl_cap_acptx_sched.sv
// rtl/tc_pl_cap_acptx_sched.sv - round-robin ACP TX capture engine scheduler with per-channel ring pointers
module tc_pl_cap_acptx_sched #(
    parameter int CH_NUM      = 4,
    parameter int SEL_W       = 2,
    parameter int BURST_BYTES = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    input  logic [CH_NUM*32-1:0] cfg_base_addr,
    input  logic [31:0]          cfg_ring_size,
    input  logic [7:0]           cfg_quantum,
    input  logic [CH_NUM-1:0]    ch_req,
    tc_pl_cap_acptx_sched_if.master eng,
    output logic [CH_NUM*32-1:0] ch_wptr,
    output logic                 sched_busy,
    output logic                 sched_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        RUN  = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      ring_q;
    logic [7:0]       quantum_q;
    logic [7:0]       burst_cnt;
    logic [SEL_W-1:0] last_grant;
    logic [31:0]      wptr_q [CH_NUM];

    logic [SEL_W-1:0] pick_ch;
    logic [SEL_W-1:0] idx;
    logic             pick_vld;
    logic [31:0]      pick_base;
    logic [31:0]      pick_wptr;
    logic [31:0]      cur_wptr;
    logic [31:0]      adv_raw;
    logic [31:0]      adv_wptr;
    logic             wrap;
    logic [7:0]       cnt_nxt;
    logic             quantum_hit;
    logic             release_grant;

    // Expose the pointer array as the flat output bus
    for (genvar i = 0; i < CH_NUM; i++) begin : g_wptr
        assign ch_wptr[32*i +: 32] = wptr_q[i];
    end

    // Round-robin search starting just past the last granted channel; SEL_W-bit add wraps modulo CH_NUM
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = last_grant;
        idx      = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx = last_grant + SEL_W'(k);
            if (!pick_vld && ch_req[idx]) begin
                pick_vld = 1'b1;
                pick_ch  = idx;
            end
        end
    end

    // Base and pointer of the channel about to be granted
    always_comb begin
        pick_base = '0;
        pick_wptr = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (SEL_W'(i) == pick_ch) begin
                pick_base = cfg_base_addr[32*i +: 32];
                pick_wptr = wptr_q[i];
            end
        end
    end

    // Pointer advance and grant-release decision for the active channel
    always_comb begin
        cur_wptr      = wptr_q[eng.eng_sel];
        adv_raw       = cur_wptr + 32'(BURST_BYTES);
        wrap          = (adv_raw == ring_q);
        adv_wptr      = wrap ? 32'd0 : adv_raw;
        cnt_nxt       = burst_cnt + 8'd1;
        quantum_hit   = (quantum_q != 8'd0) && (cnt_nxt == quantum_q);
        release_grant = eng.eng_tacp_cmpt ||
                        (eng.eng_burst_done && (wrap || quantum_hit || !sched_en));
    end

    // Scheduler FSM with registered engine controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ring_q           <= '0;
            quantum_q        <= '0;
            burst_cnt        <= '0;
            last_grant       <= SEL_W'(CH_NUM - 1);
            eng.eng_sel      <= '0;
            eng.eng_tacp_en  <= 1'b0;
            eng.eng_cap_addr <= '0;
            sched_busy       <= 1'b0;
            sched_done       <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                wptr_q[i] <= '0;
            end
        end else begin
            sched_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sched_en) begin
                        ring_q     <= cfg_ring_size;
                        quantum_q  <= cfg_quantum;
                        sched_busy <= 1'b1;
                        state      <= PICK;
                        for (int i = 0; i < CH_NUM; i++) begin
                            wptr_q[i] <= '0;
                        end
                    end
                end
                PICK: begin
                    if (!sched_en) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                        sched_done <= 1'b1;
                    end else if (pick_vld) begin
                        eng.eng_sel      <= pick_ch;
                        eng.eng_cap_addr <= pick_base + pick_wptr;
                        eng.eng_tacp_en  <= 1'b1;
                        last_grant       <= pick_ch;
                        burst_cnt        <= '0;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (eng.eng_burst_done) begin
                        wptr_q[eng.eng_sel] <= adv_wptr;
                        burst_cnt           <= cnt_nxt;
                    end
                    if (release_grant) begin
                        eng.eng_tacp_en <= 1'b0;
                        state           <= REL;
                    end
                end
                REL: begin
                    state <= PICK;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_pl_cap_acptx_sched.sv
// tb/tb_tc_pl_cap_acptx_sched.sv - self-checking bench for the ACP TX capture scheduler
module tb_tc_pl_cap_acptx_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         sched_en;
    logic [127:0] cfg_base_addr;
    logic [31:0]  cfg_ring_size;
    logic [7:0]   cfg_quantum;
    logic [3:0]   ch_req;
    logic [127:0] ch_wptr;
    logic         sched_busy;
    logic         sched_done;

    always #5 clk = ~clk;

    tc_pl_cap_acptx_sched_if #(.SEL_W(2)) eng_if ();

    tc_pl_cap_acptx_sched #(
        .CH_NUM(4), .SEL_W(2), .BURST_BYTES(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sched_en(sched_en),
        .cfg_base_addr(cfg_base_addr),
        .cfg_ring_size(cfg_ring_size),
        .cfg_quantum(cfg_quantum),
        .ch_req(ch_req),
        .eng(eng_if),
        .ch_wptr(ch_wptr),
        .sched_busy(sched_busy),
        .sched_done(sched_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
    } grant_t;
    grant_t sb_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  exp_sel;
        logic [31:0] exp_off;
    } vec_t;
    vec_t tbl[9];

    logic [31:0] base_v [4];
    logic [31:0] m_wptr [4];
    logic [1:0]  m_last;
    logic [1:0]  m_cur;
    logic [31:0] m_ring;
    logic [7:0]  m_q;
    logic [7:0]  m_cnt;
    logic        prev_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = last + 2'(k);
            if (req[c]) return c;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_last = 2'd3;
        for (int i = 0; i < 4; i++) m_wptr[i] = 32'd0;
    endtask

    task automatic expect_grant();
        grant_t g;
        m_cur  = rr_pick(m_last, ch_req);
        m_last = m_cur;
        m_cnt  = 8'd0;
        g.sel  = m_cur;
        g.addr = base_v[m_cur] + m_wptr[m_cur];
        sb_q.push_back(g);
    endtask

    task automatic wait_en(input logic lvl, input string name);
        int i;
        i = 0;
        while (eng_if.eng_tacp_en !== lvl && i < 40) begin
            tick();
            i++;
        end
        chk(name, 32'(eng_if.eng_tacp_en), 32'(lvl));
    endtask

    // One engine cycle with the given done/cmpt pulses; the model predicts pointer and release
    task automatic pulse(input logic bd, input logic cm, input string name);
        logic [31:0] adv;
        logic        wrap;
        logic        rel;
        int          c;
        eng_if.eng_burst_done = bd;
        eng_if.eng_tacp_cmpt  = cm;
        tick();
        eng_if.eng_burst_done = 1'b0;
        eng_if.eng_tacp_cmpt  = 1'b0;
        wrap = 1'b0;
        c = int'(m_cur);
        if (bd) begin
            adv       = m_wptr[c] + 32'd128;
            wrap      = (adv == m_ring);
            m_wptr[c] = wrap ? 32'd0 : adv;
            m_cnt     = m_cnt + 8'd1;
        end
        rel = cm | (bd & (wrap | ((m_q != 8'd0) && (m_cnt == m_q)) | !sched_en));
        chk({name, "_wptr"}, ch_wptr[32*c +: 32], m_wptr[c]);
        chk({name, "_en"}, 32'(eng_if.eng_tacp_en), 32'(!rel));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sched_en = 1'b0;
        ch_req = 4'h0;
        eng_if.eng_burst_done = 1'b0;
        eng_if.eng_tacp_cmpt  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_cfg(input logic [31:0] ring, input logic [7:0] q);
        cfg_ring_size = ring;
        cfg_quantum   = q;
        m_ring        = ring;
        m_q           = q;
    endtask

    // Grant monitor: every rising eng_tacp_en must match the oldest expected grant
    always @(negedge clk) begin
        grant_t g;
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (eng_if.eng_tacp_en && !prev_en) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: got sel %0d addr 0x%0h, required no grant",
                             eng_if.eng_sel, eng_if.eng_cap_addr);
                end else begin
                    g = sb_q.pop_front();
                    chk("sb_sel", 32'(eng_if.eng_sel), 32'(g.sel));
                    chk("sb_addr", eng_if.eng_cap_addr, g.addr);
                end
            end
            prev_en = eng_if.eng_tacp_en;
        end
    end

    initial begin
        int dcnt;
        for (int i = 0; i < 4; i++) begin
            base_v[i] = 32'h1000_0000 + 32'(i) * 32'h0100_0000;
            cfg_base_addr[32*i +: 32] = base_v[i];
        end
        prev_en = 1'b0;
        set_cfg(32'h400, 8'd0);
        tbl[0] = '{4'b1111, 2'd0, 32'h000};
        tbl[1] = '{4'b1111, 2'd1, 32'h000};
        tbl[2] = '{4'b1111, 2'd2, 32'h000};
        tbl[3] = '{4'b1111, 2'd3, 32'h000};
        tbl[4] = '{4'b1111, 2'd0, 32'h100};
        tbl[5] = '{4'b0100, 2'd2, 32'h100};
        tbl[6] = '{4'b0100, 2'd2, 32'h200};
        tbl[7] = '{4'b1010, 2'd3, 32'h100};
        tbl[8] = '{4'b1010, 2'd1, 32'h100};

        // Reset state
        do_reset();
        chk("rst_en", 32'(eng_if.eng_tacp_en), 32'd0);
        chk("rst_sel", 32'(eng_if.eng_sel), 32'd0);
        chk("rst_addr", eng_if.eng_cap_addr, 32'd0);
        chk("rst_busy", 32'(sched_busy), 32'd0);
        chk("rst_done", 32'(sched_done), 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_wptr", ch_wptr[32*i +: 32], 32'd0);

        // Single channel, three bursts then cmpt
        set_cfg(32'h400, 8'd0);
        ch_req = 4'b0001;
        sched_en = 1'b1;
        expect_grant();
        tick();
        chk("t1_pick_busy", 32'(sched_busy), 32'd1);
        chk("t1_pick_en", 32'(eng_if.eng_tacp_en), 32'd0);
        tick();
        chk("t1_en_rise", 32'(eng_if.eng_tacp_en), 32'd1);
        chk("t1_addr", eng_if.eng_cap_addr, 32'h1000_0000);
        for (int b = 0; b < 3; b++) begin
            pulse(1'b1, 1'b0, "t1_burst");
            tick();
        end
        chk("t1_wptr0", ch_wptr[31:0], 32'h180);
        pulse(1'b0, 1'b1, "t1_cmpt");
        expect_grant();
        tick();
        chk("t1_rel_one_cycle", 32'(eng_if.eng_tacp_en), 32'd0);
        tick();
        chk("t1_regrant", 32'(eng_if.eng_tacp_en), 32'd1);
        chk("t1_regrant_addr", eng_if.eng_cap_addr, 32'h1000_0180);
        pulse(1'b0, 1'b1, "t1_cmpt2");

        // Round robin with quantum 2 and idle-channel skipping
        do_reset();
        set_cfg(32'h400, 8'd2);
        for (int i = 0; i < 9; i++) begin
            ch_req = tbl[i].req;
            sched_en = 1'b1;
            expect_grant();
            wait_en(1'b1, "t2_grant");
            chk("t2_sel", 32'(eng_if.eng_sel), 32'(tbl[i].exp_sel));
            chk("t2_addr", eng_if.eng_cap_addr, base_v[tbl[i].exp_sel] + tbl[i].exp_off);
            tick();
            pulse(1'b1, 1'b0, "t2_b1");
            tick();
            pulse(1'b1, 1'b0, "t2_b2");
        end

        // Ring wrap on channel 1, then simultaneous done and cmpt
        do_reset();
        set_cfg(32'h200, 8'd0);
        ch_req = 4'b0010;
        sched_en = 1'b1;
        expect_grant();
        wait_en(1'b1, "t3_grant");
        for (int b = 0; b < 3; b++) begin
            pulse(1'b1, 1'b0, "t3_fill");
            tick();
        end
        pulse(1'b0, 1'b1, "t3_cmpt");
        expect_grant();
        wait_en(1'b1, "t3_grant2");
        chk("t3_addr_pre_wrap", eng_if.eng_cap_addr, 32'h1100_0180);
        pulse(1'b1, 1'b0, "t3_wrap");
        chk("t3_wptr1_zero", ch_wptr[63:32], 32'd0);
        expect_grant();
        wait_en(1'b1, "t3_grant3");
        chk("t3_addr_base1", eng_if.eng_cap_addr, 32'h1100_0000);
        pulse(1'b1, 1'b1, "t3_done_cmpt");
        chk("t3_wptr1_adv", ch_wptr[63:32], 32'h80);

        // Graceful stop: grant held until the next burst completes
        expect_grant();
        wait_en(1'b1, "t4_grant");
        sched_en = 1'b0;
        tick();
        tick();
        chk("t4_hold_en", 32'(eng_if.eng_tacp_en), 32'd1);
        pulse(1'b1, 1'b0, "t4_stop");
        chk("t4_busy_rel", 32'(sched_busy), 32'd1);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (sched_done) dcnt++;
        end
        chk("t4_done_pulses", 32'(dcnt), 32'd1);
        chk("t4_busy_idle", 32'(sched_busy), 32'd0);

        // Reset in the middle of a grant
        do_reset();
        set_cfg(32'h400, 8'd0);
        ch_req = 4'b0100;
        sched_en = 1'b1;
        expect_grant();
        wait_en(1'b1, "t5_grant");
        pulse(1'b1, 1'b0, "t5_burst");
        ch_req = 4'b1111;
        rst = 1'b1;
        tick();
        chk("t5_rst_en", 32'(eng_if.eng_tacp_en), 32'd0);
        chk("t5_rst_sel", 32'(eng_if.eng_sel), 32'd0);
        chk("t5_rst_addr", eng_if.eng_cap_addr, 32'd0);
        chk("t5_rst_wptr2", ch_wptr[95:64], 32'd0);
        chk("t5_rst_busy", 32'(sched_busy), 32'd0);
        rst = 1'b0;
        model_reset();
        expect_grant();
        wait_en(1'b1, "t5_grant_after");
        chk("t5_first_sel", 32'(eng_if.eng_sel), 32'd0);
        pulse(1'b0, 1'b1, "t5_cmpt");
        sched_en = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("t5_idle_busy", 32'(sched_busy), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tc_pl_cap_acptx_sched.md
Name: tc_pl_cap_acptx_sched

Overview:
- Round-robin scheduler that shares one ACP TX capture engine and its ACP0 write port between CH_NUM capture channels.
- Selects a channel with pending data and drives the engine's mux select, enable and start address.
- Tracks a per-channel write pointer inside a circular DDR region.
- Releases the engine on completion, on quantum expiry, or at the ring end, so that no ACP burst ever straddles the ring boundary.

Parameters:
- CH_NUM, 4, number of capture channels. Power of two, 2..8.
- SEL_W, 2, width of the channel select. Equals log2(CH_NUM).
- BURST_BYTES, 128, bytes written per ACP burst (16 beats of 64 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sched_en  in  1  level; enables scheduling
- cfg_base_addr  in  CH_NUM*32  per-channel ring base; channel i occupies bits [32*i+:32]
- cfg_ring_size  in  32  ring size in bytes; nonzero multiple of BURST_BYTES
- cfg_quantum  in  8  maximum bursts per grant; 0 means unlimited
- ch_req  in  CH_NUM  channel i buffer is non-empty
- eng_sel  out  SEL_W  selects the channel buffer and muxes it to the engine
- eng_tacp_en  out  1  engine enable
- eng_cap_addr  out  32  engine start address
- eng_tacp_cmpt  in  1  engine found its buffer empty
- eng_burst_done  in  1  one-cycle pulse in the cycle the final data handshake of a burst completes
- ch_wptr  out  CH_NUM*32  per-channel byte offset within the ring
- sched_busy  out  1  high whenever the FSM is not in IDLE
- sched_done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <= IDLE.
  - All outputs <= 0, including every ch_wptr.
  - last_grant <= CH_NUM-1, so the first grant goes to channel 0.
  - A reset mid-grant drops eng_tacp_en on the following cycle with no further handshakes.
- IDLE:
  - When sched_en=1, latch cfg_ring_size and cfg_quantum, clear all ch_wptr, go to PICK.
  - cfg_base_addr is not latched and must be stable while sched_busy=1.
- PICK:
  - If sched_en=0: go to IDLE and pulse sched_done.
  - Otherwise, if ch_req is nonzero, choose the first requesting channel searching from last_grant+1 upward with modulo wrap. Then register:
    - eng_sel <= chosen channel
    - eng_cap_addr <= base[ch] + ch_wptr[ch], 32-bit wrapping add
    - eng_tacp_en <= 1
    - last_grant <= chosen channel
    - burst counter <= 0
    - state <= RUN
  - If ch_req is zero, stay in PICK.
  - Latency from PICK to eng_tacp_en high is 1 cycle.
- RUN:
  - On eng_burst_done:
    - ch_wptr[eng_sel] += BURST_BYTES; if the result equals the ring size, it becomes 0.
    - Burst counter increments.
  - The grant ends on the same clk edge (eng_tacp_en <= 0, go to REL) on whichever comes first:
    - eng_tacp_cmpt=1
    - eng_burst_done together with a ring wrap
    - eng_burst_done with burst count+1 == quantum (quantum != 0)
    - eng_burst_done while sched_en=0
  - eng_tacp_en is never dropped outside these events. sched_en=0 with no burst in flight waits for cmpt or the next burst_done.
  - eng_tacp_cmpt and eng_burst_done in the same cycle: apply the pointer advance, then release.
- REL:
  - One idle cycle with eng_tacp_en=0, which lets the engine reset.
  - Then go to PICK.
  - eng_sel is held through REL.
- Pointer arithmetic:
  - Offsets are modulo the ring size; wrap is exact because the ring size is a multiple of BURST_BYTES.
  - Pointers persist across grants and are cleared only on reset or on leaving IDLE.
- eng_cap_addr is held constant from PICK until the next PICK.
- sched_busy = (state != IDLE), registered.

Test Plan:
- Single burst run:
  - Stimulus: ch_req=0001, base0=0x1000_0000, ring=0x400, quantum=0; three burst_done pulses, then cmpt.
  - Required: eng_tacp_en rises 1 cycle after PICK; eng_cap_addr=0x1000_0000; ch_wptr0=0x180; en falls on the cmpt edge; exactly one REL cycle before the next PICK.
- Round-robin with quantum:
  - Stimulus: ch_req=1111, quantum=2, engine never cmpts.
  - Required: grants in order 0,1,2,3,0; each en falls on the edge of the 2nd burst_done; second grant of ch0 has eng_cap_addr=base0+0x100.
- Ring wrap:
  - Stimulus: ring=0x200, ch1 wptr=0x180, one burst_done.
  - Required: ch_wptr1=0 and en falls on the same edge; next ch1 grant has eng_cap_addr=base1.
- Skip idle channels:
  - Stimulus: ch_req=0100, last_grant=2.
  - Required: channel 2 is regranted; eng_sel=2.
- Graceful stop:
  - Stimulus: sched_en=0 mid-RUN.
  - Required: en held until the next burst_done, then REL, PICK, IDLE; one sched_done pulse; sched_busy=0.
- Reset mid-run:
  - Stimulus: rst=1 during RUN with ch_wptr2=0x80.
  - Required: next cycle all outputs 0, ch_wptr2=0; after release, the first grant goes to channel 0.
